// File: rtl/source_run_sequencer.sv
// Turns host run commands {clr, N, charges} into N source packets: charges and
// CLR ride on the first packet, FIN on the last, zero charges in between.
module source_run_sequencer #(
  parameter  int NUM_INP      = 4,
  parameter  int CHARGE_WIDTH = 8,
  parameter  int RUN_WIDTH    = 16,
  localparam int PKT_WIDTH    = 2 + NUM_INP * CHARGE_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_clr,
  input  logic [RUN_WIDTH-1:0]              cmd_runs,
  input  logic [NUM_INP*CHARGE_WIDTH-1:0]   cmd_inp,
  output logic                              pkt_valid,
  input  logic                              pkt_ready,
  output logic [PKT_WIDTH-1:0]              pkt,
  output logic                              busy,
  output logic                              done,
  output logic [RUN_WIDTH-1:0]              runs_left
);

  localparam int VEC_W = NUM_INP * CHARGE_WIDTH;
  localparam logic [RUN_WIDTH-1:0] RUN_ZERO = '0;
  localparam logic [RUN_WIDTH-1:0] RUN_ONE  = RUN_WIDTH'(1);
  localparam logic [RUN_WIDTH-1:0] RUN_TWO  = RUN_WIDTH'(2);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic                   pkt_valid_q, pkt_valid_d;
  logic [PKT_WIDTH-1:0]   pkt_q, pkt_d;
  logic [RUN_WIDTH-1:0]   runs_left_q, runs_left_d;
  logic                   done_q, done_d;

  function automatic logic [PKT_WIDTH-1:0] make_pkt(input logic clr,
                                                    input logic fin,
                                                    input logic [VEC_W-1:0] vec);
    return {clr, fin, vec};
  endfunction

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == EMIT);
  assign pkt_valid = pkt_valid_q;
  assign pkt       = pkt_q;
  assign runs_left = runs_left_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    pkt_valid_d = pkt_valid_q;
    pkt_d       = pkt_q;
    runs_left_d = runs_left_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_runs != RUN_ZERO) begin
            state_d     = EMIT;
            pkt_valid_d = 1'b1;
            pkt_d       = make_pkt(cmd_clr, cmd_runs == RUN_ONE, cmd_inp);
            runs_left_d = cmd_runs;
          end else if (cmd_clr) begin
            // A zero-length run that still clears emits one bare CLR+FIN packet.
            state_d     = EMIT;
            pkt_valid_d = 1'b1;
            pkt_d       = make_pkt(1'b1, 1'b1, '0);
            runs_left_d = RUN_ONE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (pkt_valid_q && pkt_ready && runs_left_q != RUN_ZERO) begin
          runs_left_d = runs_left_q - RUN_ONE;
          if (runs_left_q == RUN_ONE) begin
            state_d     = IDLE;
            pkt_valid_d = 1'b0;
            pkt_d       = '0;
            done_d      = 1'b1;
          end else begin
            pkt_d = make_pkt(1'b0, runs_left_q == RUN_TWO, '0);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pkt_valid_q <= 1'b0;
      pkt_q       <= '0;
      runs_left_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_q       <= pkt_d;
      runs_left_q <= runs_left_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: doc/source_run_sequencer.md
Name: source_run_sequencer

Overview:
- Converts host run commands into the packet stream consumed by the network source stage.
- Each command is {clear flag, run count N, input charge vector}. The block emits N packets: the first carries the charges and the optional clear flag, the rest carry zero charges, and the last carries FIN.
- Sits between the host command decoder and the network source; owns timestep sequencing and end-of-run signalling.

Parameters:
- NUM_INP, 4, number of network inputs.
- CHARGE_WIDTH, 8, signed charge width per input.
- RUN_WIDTH, 16, width of the run-count field.
- PKT_WIDTH, 2+NUM_INP*CHARGE_WIDTH, packet width (derived; do not override).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command handshake valid.
- cmd_ready  out  1  command handshake ready.
- cmd_clr  in  1  clear network before the first timestep.
- cmd_runs  in  RUN_WIDTH  number of timesteps N (unsigned).
- cmd_inp  in  NUM_INP*CHARGE_WIDTH  charges; input i at [(NUM_INP-i)*CHARGE_WIDTH-1 -: CHARGE_WIDTH].
- pkt_valid  out  1  packet stream valid.
- pkt_ready  in  1  packet stream ready.
- pkt  out  PKT_WIDTH  bit PKT_WIDTH-1 = CLR, bit PKT_WIDTH-2 = FIN, lower bits = charge vector (same layout as cmd_inp).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after a command completes.
- runs_left  out  RUN_WIDTH  packets still to be handshaken for the current command.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - pkt_valid=0, pkt=0, busy=0, done=0, runs_left=0.
  - cmd_ready=1 in the cycle after the reset edge.
  - Reset mid-run drops pkt_valid at the next edge regardless of pkt_ready; the partial run is discarded and done is not pulsed.
- States: IDLE, EMIT.
  - cmd_ready = (state==IDLE), combinational from state only.
  - busy = (state==EMIT).
- IDLE, on cmd_valid&&cmd_ready:
  - N>=1: go to EMIT. Next cycle present pkt={cmd_clr, N==1, cmd_inp} with pkt_valid=1 and runs_left=N.
  - N==0 and cmd_clr=1: go to EMIT with one packet {1,1,zeros}; runs_left=1.
  - N==0 and cmd_clr=0: no packet, stay IDLE, done=1 next cycle.
- EMIT, on pkt_valid&&pkt_ready:
  - runs_left decrements.
  - If runs_left was 1: pkt_valid=0 and state=IDLE next cycle, with done=1 in that cycle.
  - Otherwise the next packet is {0, runs_left==2, zeros}, with pkt_valid held high (no bubble between packets).
- Stream rules:
  - pkt and pkt_valid are registered outputs.
  - While pkt_valid && !pkt_ready, pkt is held stable and pkt_valid stays 1.
  - pkt_valid never depends combinationally on pkt_ready.
  - One packet per cycle sustained when pkt_ready=1.
- Command latency:
  - First packet appears exactly 1 cycle after the command handshake.
  - The next command can be accepted in the done cycle, so a minimum of 1 idle cycle on the stream between commands.
- Command fields are captured at the handshake; cmd_* changes afterwards have no effect.
- done is 0 in all cycles except the single pulse. done does not block acceptance: a command may handshake in the done cycle.
- Counters and arithmetic:
  - runs_left is unsigned RUN_WIDTH and never underflows.
  - N = 2^RUN_WIDTH-1 is a legal maximum.
- FIN is set on exactly one packet per command: the last one. CLR is set at most on the first packet.

Test Plan:
- Reset, then cmd {clr=1, N=3, charges 5,-2,0,7}, pkt_ready=1 → pkts {1,0,05 FE 00 07}, {0,0,0}, {0,1,0} on consecutive cycles; done pulses the cycle after the 3rd; runs_left goes 3,2,1,0.
- Same cmd with pkt_ready toggling 0/1 every cycle → pkt stable across stalls; exactly 3 handshakes; FIN only on the third.
- cmd {clr=0, N=0} → no pkt_valid; done=1 one cycle after the handshake; cmd_ready stays 1. cmd {clr=1, N=0} → single pkt {1,1,0}.
- Back-to-back: hold cmd_valid=1 with N=1 twice → second handshake in the done cycle; two packets separated by exactly 1 cycle of pkt_valid=0.
- rst asserted while N=10 run is at runs_left=6 with pkt_ready=0 → pkt_valid=0, runs_left=0, busy=0 next cycle; no done; new command then runs normally.
- N=1, clr=1 → single packet with both CLR and FIN set and charges present.
